// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and field widths for the UART TX scheduler
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;
  localparam int BYTE_W = 8;
  localparam int CODE_W = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick searching upward from ptr+1
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);
  logic [PW-1:0] idx;
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) pick = N'(1) << idx;
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler into a UART TX FIFO with drained config apply
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_PKT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BYTE_W-1:0]   data,
  input  logic [NREQ-1:0]          last,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output logic [BYTE_W-1:0]        data_out,
  input  logic                     fifo_full,
  input  logic                     fifo_emp,
  input  logic                     tx_active,
  input  logic                     cfg_wr,
  input  logic [CODE_W-1:0]        cfg_baud,
  input  logic [CODE_W-1:0]        cfg_parity,
  output logic [CODE_W-1:0]        baud_rate,
  output logic [CODE_W-1:0]        parity_type,
  output logic                     cfg_busy,
  output logic                     cfg_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] pend_baud;
  logic [CODE_W-1:0] pend_par;
  logic [NREQ-1:0]   pick;
  logic              owner_last;
  logic              release_now;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .pick(pick)
  );

  // decode the one-hot owner into its index, byte and last flag; zero when unowned
  always_comb begin
    owner      = '0;
    data_out   = '0;
    owner_last = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        owner      = PW'(i);
        data_out   = data[i*BYTE_W +: BYTE_W];
        owner_last = last[i];
      end
  end

  // acks are combinational so a byte moves in the same cycle the FIFO has room
  assign ack         = (state == XFER && !fifo_full) ? (gnt & req) : '0;
  assign wr_en       = |ack;
  assign release_now = wr_en && (owner_last || cnt == CW'(MAX_PKT - 1));

  // grant/transfer/drain sequencing plus config capture, which is accepted in every state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      ptr         <= PW'(NREQ - 1);
      cnt         <= '0;
      pend_baud   <= '0;
      pend_par    <= '0;
      baud_rate   <= '0;
      parity_type <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_wr) begin
        pend_baud <= cfg_baud;
        pend_par  <= cfg_parity;
        cfg_busy  <= 1'b1;
      end
      case (state)
        IDLE:
          if (cfg_busy) state <= DRAIN;
          else if (|req) begin
            gnt   <= pick;
            state <= XFER;
          end
        XFER:
          if (release_now) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= owner;
          end else if (wr_en) cnt <= cnt + CW'(1);
        DRAIN:
          if (fifo_emp && !tx_active) begin
            baud_rate   <= pend_baud;
            parity_type <= pend_par;
            cfg_busy    <= cfg_wr;
            cfg_done    <= 1'b1;
            state       <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; both ports are named as listed below.
REQ-002 Parameter NREQ, default 4: number of requesters.
REQ-003 Parameter MAX_PKT, default 16: maximum bytes per grant before forced release.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester request; held high until its last byte is acked.
REQ-007 data  in  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 last  in  NREQ  per-requester flag marking the final byte of a packet.
REQ-009 ack  out  NREQ  per-requester byte-accepted strobe.
REQ-010 gnt  out  NREQ  one-hot current owner; all zero when no owner.
REQ-011 wr_en  out  1  write strobe to the transmitter FIFO.
REQ-012 data_out  out  8  byte to the transmitter FIFO.
REQ-013 fifo_full, fifo_emp, tx_active  in  1 each  transmitter FIFO and shifter status.
REQ-014 cfg_wr  in  1  config request pulse; cfg_baud[1:0] and cfg_parity[1:0] are sampled with it.
REQ-015 baud_rate, parity_type  out  2 each  applied configuration to the transmitter.
REQ-016 cfg_busy  out  1  config pending; cfg_done  out  1  one-cycle pulse when config is applied.

Function
REQ-017 The FSM SHALL have three states, IDLE, XFER and DRAIN, encoded as 2 bits.
REQ-018 In IDLE with cfg pending, the next state SHALL be DRAIN; pending config takes priority over requests.
REQ-019 In IDLE with no cfg pending and any req high, the block SHALL grant round-robin, searching from (last owner + 1) mod NREQ, register gnt, and go to XFER.
REQ-020 In XFER, ack[i] = wr_en = gnt[i] & req[i] & !fifo_full, combinationally; no registered latency.
REQ-021 data_out SHALL equal the granted requester's data whenever gnt is nonzero, and 0 otherwise.
REQ-022 fifo_full high SHALL stall transfers with gnt held; no byte is lost or duplicated.
REQ-023 If req drops mid-packet, gnt SHALL be held and wr_en stays low until req returns.
REQ-024 A per-grant byte counter SHALL count acks; release occurs on an ack with last=1 or on ack number MAX_PKT.
REQ-025 On release: next state IDLE, gnt cleared, counter cleared, rr pointer updated to the released owner.
REQ-026 There SHALL be one idle cycle between grants; back-to-back packets from the same requester are allowed only if no other requester is pending.
REQ-027 cfg_wr SHALL load the pending registers and set cfg_busy in any state; a second cfg_wr while pending overwrites the values.
REQ-028 cfg_wr in the same cycle as a releasing ack SHALL still be captured; the next IDLE goes to DRAIN.
REQ-029 DRAIN: no grants; when fifo_emp=1 and tx_active=0, the block SHALL load baud_rate/parity_type, clear cfg_busy, pulse cfg_done for one cycle, and go to IDLE.
REQ-030 cfg_wr in the cycle of apply: the new values SHALL stay pending, cfg_busy stays 1, and the next IDLE returns to DRAIN.

Reset
REQ-031 With rst_n low, the block SHALL be in IDLE with gnt=0, ack=0, wr_en=0, data_out=0, baud_rate=0, parity_type=0, cfg_busy=0, cfg_done=0, counter=0, and rr pointer at NREQ-1 (so requester 0 wins first).
REQ-032 Reset mid-packet SHALL abandon the packet with no FIFO write on the reset edge.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state typedef, the byte width (8), and the baud/parity code widths (2).
REQ-034 The round-robin picker SHALL be one sub-module, rr_arbiter (req, pointer -> one-hot pick).

Verification
REQ-035 Req=4'b0101 with 3-byte packets each -> requester 0 sends bytes A0..A2, one idle cycle, then requester 2 sends C0..C2; wr_en count is 6.
REQ-036 Requester 1 sends a 20-byte packet with no last until byte 20 -> release after byte 16; requester 1 is re-granted for the remaining 4 bytes if alone.
REQ-037 fifo_full asserted for 5 cycles mid-packet -> wr_en=0 for those 5 cycles, gnt unchanged, sequence intact.
REQ-038 cfg_wr(baud=2, parity=1) during XFER -> packet completes, DRAIN until fifo_emp=1 and tx_active=0, then baud_rate=2, parity_type=1, cfg_done=1 for 1 cycle.
REQ-039 All four requesters continuously requesting 1-byte packets -> grant order 0,1,2,3,0.
REQ-040 rst_n pulsed low during XFER -> all outputs reach REQ-031 values asynchronously, and the first grant after reset goes to requester 0.
